// File: rtl/counter_pkg.sv
// Shared types and constants for the count SPI readout block.
//   CNT_W          width of count inputs and of each per-gate delta
//   FRAME_BITS     length of the SPI frame sent to the host
//   state_t        readout FSM states
//   snapshot_t     one gate period's result (sequence number and two deltas)
//   build_frame()  packs flags and a snapshot into the 64-bit frame with its XOR check byte
package counter_pkg;

  localparam int unsigned CNT_W          = 24;
  localparam int unsigned FRAME_BITS     = 64;
  localparam int unsigned SEQ_W          = 6;
  localparam int unsigned B0_VALID_BIT   = 7;
  localparam int unsigned B0_OVERRUN_BIT = 6;
  localparam int unsigned BIT_CNT_W      = $clog2(FRAME_BITS) + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  typedef struct packed {
    logic [SEQ_W-1:0] seq;
    logic [CNT_W-1:0] delta_p;
    logic [CNT_W-1:0] delta_m;
  } snapshot_t;

  // Frame layout: byte0 flags+seq, bytes1-3 delta_p, bytes4-6 delta_m, byte7 XOR of bytes0-6.
  function automatic logic [FRAME_BITS-1:0] build_frame(input logic valid, input logic ovr,
                                                        input snapshot_t snap);
    logic [7:0]  byte0;
    logic [55:0] body;
    logic [7:0]  chk;
    byte0                 = '0;
    byte0[B0_VALID_BIT]   = valid;
    byte0[B0_OVERRUN_BIT] = ovr;
    byte0[SEQ_W-1:0]      = snap.seq;
    body                  = {byte0, snap.delta_p, snap.delta_m};
    chk                   = '0;
    for (int i = 0; i < 7; i++) chk = chk ^ body[8*i +: 8];
    return {body, chk};
  endfunction

endpackage

// File: rtl/spi_edge_sync.sv
// Multi-flop synchroniser for one asynchronous SPI pin with edge pulses.
//   clk     system clock
//   rst_n   synchronous reset, active-low
//   din     raw asynchronous pin
//   rise_c  one-cycle pulse on a synchronised 0->1 transition
//   fall_c  one-cycle pulse on a synchronised 1->0 transition
module spi_edge_sync #(
  parameter int unsigned STAGES    = 2,
  parameter logic        RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic rise_c,
  output logic fall_c
);

  logic [STAGES-1:0] sync;
  logic              prev;

  // Reset value matches the pin's idle level so releasing reset makes no false edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync <= {STAGES{RESET_VAL}};
      prev <= RESET_VAL;
    end else begin
      sync <= STAGES'({sync, din});
      prev <= sync[STAGES-1];
    end
  end

  assign rise_c = sync[STAGES-1] & ~prev;
  assign fall_c = ~sync[STAGES-1] & prev;

endmodule

// File: rtl/count_spi_readout.sv
// Samples free-running count_p/count_m once per gate period, forms wrap-safe deltas,
// and serves them to the host as a 64-bit SPI mode-0 slave frame.
//   clk_12mhz    system clock
//   reset        synchronous reset, active-low
//   count_p/m    free-running channel counts
//   spi_sclk     host SPI clock (asynchronous, synchronised here)
//   spi_cs_n     host chip select, active-low (asynchronous, synchronised here)
//   spi_miso     serial frame data, MSB first
//   frame_valid  an unread snapshot is in the shadow register
//   overrun      sticky: a snapshot was dropped since the last completed read
module count_spi_readout
  import counter_pkg::*;
#(
  parameter int unsigned GATE_TICKS  = 12_000_000,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk_12mhz,
  input  logic             reset,
  input  logic [CNT_W-1:0] count_p,
  input  logic [CNT_W-1:0] count_m,
  input  logic             spi_sclk,
  input  logic             spi_cs_n,
  output logic             spi_miso,
  output logic             frame_valid,
  output logic             overrun
);

  localparam int unsigned TIMER_W = $clog2(GATE_TICKS);

  logic [TIMER_W-1:0]    gate_cnt;
  logic                  gate_tick_c;
  logic [CNT_W-1:0]      prev_p;
  logic [CNT_W-1:0]      prev_m;
  logic [SEQ_W-1:0]      seq;
  snapshot_t             new_snap_c;
  snapshot_t             shadow;
  snapshot_t             pend;
  logic                  pend_valid;
  state_t                state;
  state_t                state_next;
  logic [BIT_CNT_W-1:0]  bit_cnt;
  logic [FRAME_BITS-1:0] shift_reg;
  logic [FRAME_BITS-1:0] frame_c;
  logic                  done_clear_c;
  logic                  sclk_rise_c;
  logic                  sclk_fall_c;
  logic                  cs_rise_c;
  logic                  cs_fall_c;

  spi_edge_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sclk_sync (
    .clk    (clk_12mhz),
    .rst_n  (reset),
    .din    (spi_sclk),
    .rise_c (sclk_rise_c),
    .fall_c (sclk_fall_c)
  );

  spi_edge_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_cs_sync (
    .clk    (clk_12mhz),
    .rst_n  (reset),
    .din    (spi_cs_n),
    .rise_c (cs_rise_c),
    .fall_c (cs_fall_c)
  );

  assign gate_tick_c = (gate_cnt == TIMER_W'(GATE_TICKS - 1));

  // Modular subtraction gives the right delta across a counter wrap.
  always_comb begin
    new_snap_c         = '0;
    new_snap_c.seq     = seq + SEQ_W'(1);
    new_snap_c.delta_p = count_p - prev_p;
    new_snap_c.delta_m = count_m - prev_m;
  end

  assign frame_c      = build_frame(frame_valid, overrun, shadow);
  assign done_clear_c = (state == DONE) && (bit_cnt >= BIT_CNT_W'(FRAME_BITS));

  // FSM state register
  always_ff @(posedge clk_12mhz) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  // FSM next state; a cs_n rise during LOAD ends as an aborted read
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (cs_fall_c) state_next = LOAD;
      LOAD:    state_next = cs_rise_c ? DONE : SHIFT;
      SHIFT:   if (cs_rise_c) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Gate timer, snapshot/commit bookkeeping and the frame shifter
  always_ff @(posedge clk_12mhz) begin
    if (!reset) begin
      gate_cnt    <= '0;
      prev_p      <= '0;
      prev_m      <= '0;
      seq         <= '0;
      shadow      <= '0;
      pend        <= '0;
      pend_valid  <= 1'b0;
      frame_valid <= 1'b0;
      overrun     <= 1'b0;
      bit_cnt     <= '0;
      shift_reg   <= '0;
      spi_miso    <= 1'b0;
    end else begin
      gate_cnt <= gate_tick_c ? '0 : gate_cnt + TIMER_W'(1);

      if (gate_tick_c) begin
        prev_p <= count_p;
        prev_m <= count_m;
        seq    <= new_snap_c.seq;
      end

      // A completed read clears first; a snapshot from the same cycle then lands via pending.
      if (done_clear_c) begin
        frame_valid <= 1'b0;
        overrun     <= 1'b0;
      end

      if (gate_tick_c) begin
        if (state == IDLE) begin
          shadow      <= new_snap_c;
          frame_valid <= 1'b1;
          pend_valid  <= 1'b0;
          if (frame_valid || pend_valid) overrun <= 1'b1;
        end else begin
          pend       <= new_snap_c;
          pend_valid <= 1'b1;
          if ((frame_valid || pend_valid) && !done_clear_c) overrun <= 1'b1;
        end
      end else if ((state == IDLE) && pend_valid) begin
        shadow      <= pend;
        frame_valid <= 1'b1;
        pend_valid  <= 1'b0;
      end

      case (state)
        LOAD: begin
          shift_reg <= frame_c;
          spi_miso  <= frame_c[FRAME_BITS-1];
          bit_cnt   <= '0;
        end
        SHIFT: begin
          if (sclk_rise_c && (bit_cnt < BIT_CNT_W'(FRAME_BITS))) bit_cnt <= bit_cnt + BIT_CNT_W'(1);
          // Host samples on rise, so the next bit is presented on fall; zeros after 64 bits.
          if (sclk_fall_c) begin
            shift_reg <= {shift_reg[FRAME_BITS-2:0], 1'b0};
            spi_miso  <= (bit_cnt < BIT_CNT_W'(FRAME_BITS)) ? shift_reg[FRAME_BITS-2] : 1'b0;
          end
        end
        default: spi_miso <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_count_spi_readout.sv
// Directed bench for count_spi_readout with a 100-cycle gate period.
module tb_count_spi_readout;

  localparam int unsigned GATE = 100;
  localparam int          HALF = 4;   // sclk half period in clk cycles

  logic        clk_12mhz = 1'b0;
  logic        reset     = 1'b0;
  logic [23:0] count_p   = '0;
  logic [23:0] count_m   = '0;
  logic        spi_sclk  = 1'b0;
  logic        spi_cs_n  = 1'b1;
  logic        spi_miso;
  logic        frame_valid;
  logic        overrun;

  int unsigned ecnt;       // clock edges since reset release, mirrors the gate timer phase
  int unsigned n_checks;
  int unsigned n_pass;
  logic [63:0] rd;
  logic        pad;
  bit          saw_low;

  count_spi_readout #(.GATE_TICKS(GATE), .SYNC_STAGES(2)) dut (
    .clk_12mhz   (clk_12mhz),
    .reset       (reset),
    .count_p     (count_p),
    .count_m     (count_m),
    .spi_sclk    (spi_sclk),
    .spi_cs_n    (spi_cs_n),
    .spi_miso    (spi_miso),
    .frame_valid (frame_valid),
    .overrun     (overrun)
  );

  always #5 clk_12mhz = ~clk_12mhz;

  always @(posedge clk_12mhz) begin
    if (!reset) ecnt <= 0;
    else        ecnt <= ecnt + 1;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic wait_ecnt(input int unsigned n);
    int guard;
    guard = 0;
    while (ecnt < n && guard < 5000) begin
      @(negedge clk_12mhz);
      guard++;
    end
    if (ecnt < n) check("wait_ecnt", 64'(ecnt), 64'(n));
  endtask

  // Mode-0 host read: miso sampled just before each rising sclk, then pad sampled after the last fall.
  task automatic spi_read(input int nbits, output logic [63:0] data, output logic pad_bit);
    data = '0;
    @(negedge clk_12mhz);
    spi_cs_n = 1'b0;
    repeat (6) @(negedge clk_12mhz);
    for (int i = 0; i < nbits; i++) begin
      data     = {data[62:0], spi_miso};
      spi_sclk = 1'b1;
      repeat (HALF) @(negedge clk_12mhz);
      spi_sclk = 1'b0;
      repeat (HALF) @(negedge clk_12mhz);
    end
    pad_bit  = spi_miso;
    spi_cs_n = 1'b1;
  endtask

  task automatic watch_fv(output bit low_seen);
    low_seen = 1'b0;
    repeat (12) begin
      @(negedge clk_12mhz);
      if (!frame_valid) low_seen = 1'b1;
    end
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;

    // Reset state
    repeat (5) @(negedge clk_12mhz);
    check("rst_miso", 64'(spi_miso), 64'd0);
    check("rst_fv",   64'(frame_valid), 64'd0);
    check("rst_ov",   64'(overrun), 64'd0);
    reset = 1'b1;

    // Gate 1: count_p ramps to 37, count_m to 5
    for (int i = 0; i < 37; i++) begin
      @(negedge clk_12mhz);
      count_p = count_p + 24'd1;
      if (i < 5) count_m = count_m + 24'd1;
    end
    check("idle_miso", 64'(spi_miso), 64'd0);
    wait_ecnt(99);
    check("fv_before_tick", 64'(frame_valid), 64'd0);
    wait_ecnt(100);
    check("fv_after_tick", 64'(frame_valid), 64'd1);
    check("ov_after_tick", 64'(overrun), 64'd0);

    // Full read of the first snapshot
    wait_ecnt(101);
    spi_read(64, rd, pad);
    check("frame1", rd, 64'h81000025000005A1);
    check("frame1_pad", 64'(pad), 64'd0);
    watch_fv(saw_low);
    check("frame1_fv_cleared", 64'(saw_low), 64'd1);
    check("frame1_pending_commit", 64'(frame_valid), 64'd1);
    check("frame1_ov", 64'(overrun), 64'd0);

    // Wrap-around delta and two unread gates
    wait_ecnt(650);
    count_p = 24'hFFFFF0;
    wait_ecnt(750);
    count_p = 24'h000010;
    wait_ecnt(801);
    check("ov_two_gates", 64'(overrun), 64'd1);
    check("fv_two_gates", 64'(frame_valid), 64'd1);
    spi_read(64, rd, pad);
    check("frame2", rd, 64'hC8000020000000E8);
    check("frame2_ovbit", 64'(rd[62]), 64'd1);
    check("frame2_seq", 64'(rd[61:56]), 64'd8);
    check("frame2_delta_p_wrap", 64'(rd[55:32]), 64'h000020);
    check("frame2_pad", 64'(pad), 64'd0);
    watch_fv(saw_low);
    check("frame2_ov_cleared", 64'(overrun), 64'd0);
    check("frame2_fv", 64'(frame_valid), 64'd1);

    // Gate tick mid-SHIFT: transmitted frame is unaffected, new snapshot lands after DONE
    wait_ecnt(1401);
    fork
      spi_read(64, rd, pad);
      begin
        wait_ecnt(1850);
        count_p = 24'h000110;
        count_m = 24'd12;
      end
    join
    check("frame3_stable", rd, 64'hCE000000000000CE);
    watch_fv(saw_low);
    check("frame3_fv_cleared", 64'(saw_low), 64'd1);
    check("frame3_fv_recommit", 64'(frame_valid), 64'd1);
    check("frame3_ov", 64'(overrun), 64'd0);
    wait_ecnt(1940);
    spi_read(64, rd, pad);
    check("frame4_new_snap", rd, 64'h9300010000000795);

    // Aborted read after 20 bits keeps the flags
    watch_fv(saw_low);
    wait_ecnt(2480);
    spi_read(20, rd, pad);
    check("abort_bits", 64'(rd[19:0]), 64'h98000);
    watch_fv(saw_low);
    check("abort_fv_never_low", 64'(saw_low), 64'd0);
    check("abort_fv", 64'(frame_valid), 64'd1);
    check("abort_ov", 64'(overrun), 64'd1);

    // Reset in the middle of a read
    wait_ecnt(2670);
    check("pre_reset_fv", 64'(frame_valid), 64'd1);
    @(negedge clk_12mhz);
    spi_cs_n = 1'b0;
    repeat (6) @(negedge clk_12mhz);
    for (int i = 0; i < 30; i++) begin
      spi_sclk = 1'b1;
      repeat (HALF) @(negedge clk_12mhz);
      spi_sclk = 1'b0;
      repeat (HALF) @(negedge clk_12mhz);
    end
    reset = 1'b0;
    @(negedge clk_12mhz);
    check("midread_rst_miso", 64'(spi_miso), 64'd0);
    check("midread_rst_fv", 64'(frame_valid), 64'd0);
    check("midread_rst_ov", 64'(overrun), 64'd0);
    spi_cs_n = 1'b1;
    @(negedge clk_12mhz);
    reset = 1'b1;
    wait_ecnt(60);
    check("pending_dropped_fv", 64'(frame_valid), 64'd0);
    check("pending_dropped_miso", 64'(spi_miso), 64'd0);
    wait_ecnt(100);
    check("post_reset_tick_fv", 64'(frame_valid), 64'd1);
    check("post_reset_tick_ov", 64'(overrun), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
